// File: rtl/acc_pkg.sv
// Shared types, widths and helper functions for the accelerator-side interconnect blocks.
// The default request/response payloads carry the extended id produced by the interconnect.
package acc_pkg;

   localparam int unsigned InIdWidth = 5;
   localparam int unsigned NumReq    = 4;
   localparam int unsigned DataWidth = 32;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Interconnect appends the requester index to the incoming id.
   localparam int unsigned DefIdWidth = InIdWidth + idx_width(NumReq);

   typedef struct packed {
      logic [DefIdWidth-1:0] id;
      logic [DataWidth-1:0]  data;
   } acc_req_t;

   typedef struct packed {
      logic [DefIdWidth-1:0] id;
      logic [DataWidth-1:0]  data;
      logic                  error;
   } acc_rsp_t;

   typedef enum logic [1:0] {
      CNT_HOLD,
      CNT_INC,
      CNT_DEC
   } cnt_op_e;

endpackage

// File: rtl/acc_slv_buf_fifo.sv
// Generic synchronous FIFO with occupancy count; the head entry is presented combinationally.
// Pushes while full and pops while empty are ignored.
module acc_slv_buf_fifo import acc_pkg::*; #(
   parameter int unsigned Depth = 4,
   parameter type         dtype = logic [7:0]
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  dtype                          data_in,
   input  logic                          pop,
   output dtype                          data_out,
   output logic                          full,
   output logic                          empty,
   output logic [cnt_width(Depth)-1:0]   count
);

   localparam int unsigned PtrW = idx_width(Depth);
   localparam int unsigned CntW = cnt_width(Depth);
   localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   dtype            mem [Depth];
   logic [PtrW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CntW-1:0] count_reg;
   logic            do_push, do_pop;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
   endfunction

   assign full    = (count_reg == FullCnt);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CntW'(1);
            2'b01:   count_reg <= count_reg - CntW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage is left unreset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= data_in;
   end

   assign data_out = mem[rd_ptr_reg];

endmodule

// File: rtl/acc_slv_credit_buffer.sv
// Request buffer with outstanding-request credit limit between an interconnect slave port and an accelerator.
// Optional in-order response id checking is enabled with ACC_SLV_CREDIT_BUFFER_ID_CHECK_EN.
module acc_slv_credit_buffer import acc_pkg::*; #(
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned IdWidth        = DefIdWidth,
   parameter type         req_t          = acc_req_t,
   parameter type         rsp_t          = acc_rsp_t,
   localparam int unsigned CntW          = cnt_width(MaxOutstanding)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  req_t            slv_q_i,
   input  logic            slv_q_valid_i,
   output logic            slv_q_ready_o,
   output rsp_t            slv_p_o,
   output logic            slv_p_valid_o,
   input  logic            slv_p_ready_i,
   output req_t            acc_q_o,
   output logic            acc_q_valid_o,
   input  logic            acc_q_ready_i,
   input  rsp_t            acc_p_i,
   input  logic            acc_p_valid_i,
   output logic            acc_p_ready_o,
   output logic [CntW-1:0] outstanding_o,
   output logic            busy_o,
   output logic            id_err_o
);

   localparam int unsigned FifoCntW = cnt_width(Depth);
   localparam logic [FifoCntW-1:0] DepthCnt = FifoCntW'(Depth);
   localparam logic [CntW-1:0]     MaxCnt   = CntW'(MaxOutstanding);

   logic [FifoCntW-1:0] fifo_cnt;
   logic                fifo_full, fifo_empty;
   logic                push, issue, retire, credit_retire;
   logic [CntW-1:0]     outstanding_reg, outstanding_next;
   cnt_op_e             cnt_op;

   acc_slv_buf_fifo #(
      .Depth (Depth),
      .dtype (req_t)
   ) u_req_fifo (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .push     (push),
      .data_in  (slv_q_i),
      .pop      (issue),
      .data_out (acc_q_o),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_cnt)
   );

   // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
   assign slv_q_ready_o = (fifo_cnt != DepthCnt);
   assign push          = slv_q_valid_i & slv_q_ready_o;

   assign acc_q_valid_o = ~fifo_empty & (outstanding_reg < MaxCnt);
   assign issue         = acc_q_valid_o & acc_q_ready_i;

   assign slv_p_o       = acc_p_i;
   assign slv_p_valid_o = acc_p_valid_i;
   assign acc_p_ready_o = slv_p_ready_i;
   assign retire        = acc_p_valid_i & slv_p_ready_i;

   // A retire with nothing in flight is spurious and returns no credit.
   assign credit_retire = retire & (outstanding_reg != '0);

   always_comb begin
      cnt_op = CNT_HOLD;
      if (issue && !credit_retire)
         cnt_op = CNT_INC;
      else if (credit_retire && !issue)
         cnt_op = CNT_DEC;
   end

   always_comb begin
      outstanding_next = outstanding_reg;
      case (cnt_op)
         CNT_INC: outstanding_next = outstanding_reg + CntW'(1);
         CNT_DEC: outstanding_next = outstanding_reg - CntW'(1);
         default: outstanding_next = outstanding_reg;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outstanding_reg <= '0;
      else         outstanding_reg <= outstanding_next;
   end

   assign outstanding_o = outstanding_reg;
   assign busy_o        = ~fifo_empty | (outstanding_reg != '0);

`ifdef ACC_SLV_CREDIT_BUFFER_ID_CHECK_EN
   logic [IdWidth-1:0] id_head;
   logic               id_full, id_empty, id_mismatch, id_err_reg;
   logic [CntW-1:0]    id_cnt;

   acc_slv_buf_fifo #(
      .Depth (MaxOutstanding),
      .dtype (logic [IdWidth-1:0])
   ) u_id_fifo (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .push     (issue),
      .data_in  (acc_q_o.id),
      .pop      (credit_retire),
      .data_out (id_head),
      .full     (id_full),
      .empty    (id_empty),
      .count    (id_cnt)
   );

   assign id_mismatch = retire & ((outstanding_reg == '0) | (acc_p_i.id != id_head));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) id_err_reg <= 1'b0;
      else         id_err_reg <= id_err_reg | id_mismatch;
   end

   assign id_err_o = id_err_reg;

   logic unused_ok;
   assign unused_ok = fifo_full ^ id_full ^ id_empty ^ (^id_cnt);
`else
   assign id_err_o = 1'b0;

   logic unused_ok;
   assign unused_ok = fifo_full;
`endif

endmodule

// File: tb/tb_acc_slv_credit_buffer.sv
// Directed bench for acc_slv_credit_buffer (Depth=4, MaxOutstanding=2); expectations follow
// ACC_SLV_CREDIT_BUFFER_ID_CHECK_EN when it is defined for the build.
module tb_acc_slv_credit_buffer;
   import acc_pkg::*;

   localparam int unsigned Depth  = 4;
   localparam int unsigned MaxOut = 2;
   localparam int unsigned CntW   = cnt_width(MaxOut);
`ifdef ACC_SLV_CREDIT_BUFFER_ID_CHECK_EN
   localparam logic ErrExp = 1'b1;
`else
   localparam logic ErrExp = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_ni;
   acc_req_t        slv_q, acc_q;
   acc_rsp_t        slv_p, acc_p;
   logic            slv_q_valid, slv_q_ready, slv_p_valid, slv_p_ready;
   logic            acc_q_valid, acc_q_ready, acc_p_valid, acc_p_ready;
   logic [CntW-1:0] outstanding;
   logic            busy, id_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   acc_slv_credit_buffer #(
      .Depth          (Depth),
      .MaxOutstanding (MaxOut),
      .IdWidth        (DefIdWidth),
      .req_t          (acc_req_t),
      .rsp_t          (acc_rsp_t)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .slv_q_i       (slv_q),
      .slv_q_valid_i (slv_q_valid),
      .slv_q_ready_o (slv_q_ready),
      .slv_p_o       (slv_p),
      .slv_p_valid_o (slv_p_valid),
      .slv_p_ready_i (slv_p_ready),
      .acc_q_o       (acc_q),
      .acc_q_valid_o (acc_q_valid),
      .acc_q_ready_i (acc_q_ready),
      .acc_p_i       (acc_p),
      .acc_p_valid_i (acc_p_valid),
      .acc_p_ready_o (acc_p_ready),
      .outstanding_o (outstanding),
      .busy_o        (busy),
      .id_err_o      (id_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   initial begin
      rst_ni      = 1'b0;
      slv_q       = '0;
      slv_q.id    = 7'h01;
      slv_q_valid = 1'b1;
      slv_p_ready = 1'b1;
      acc_q_ready = 1'b0;
      acc_p       = '0;
      acc_p_valid = 1'b0;

      // Reset state while a request is already offered
      repeat (2) @(negedge clk_i);
      #1;
      check("rst_slv_q_ready", slv_q_ready, 1);
      check("rst_acc_q_valid", acc_q_valid, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_busy", busy, 0);
      check("rst_id_err", id_err, 0);
      check("rst_slv_p_valid", slv_p_valid, 0);

      // Fill with accelerator stalled: 4 accepted, 5 and 6 refused
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk_i);
         rst_ni     = 1'b1;
         slv_q.id   = 7'(i);
         slv_q.data = 32'hA000 + 32'(i);
         #1;
         check($sformatf("push%0d_ready", i), slv_q_ready, (i <= 4) ? 32'd1 : 32'd0);
         if (i == 2) begin
            check("first_push_valid", acc_q_valid, 1);
            check("first_push_id", acc_q.id, 1);
         end
      end
      @(negedge clk_i);
      slv_q_valid = 1'b0;
      #1;
      check("full_ready", slv_q_ready, 0);
      check("full_busy", busy, 1);
      check("full_head_id", acc_q.id, 1);
      check("full_head_data", acc_q.data, 32'hA001);
      check("full_outstanding", outstanding, 0);

      // Credit limit of 2
      @(negedge clk_i);
      acc_q_ready = 1'b1;
      #1;
      check("iss1_id", acc_q.id, 1);
      @(negedge clk_i);
      #1;
      check("iss2_id", acc_q.id, 2);
      check("iss2_outstanding", outstanding, 1);
      @(negedge clk_i);
      #1;
      check("cap_outstanding", outstanding, 2);
      check("cap_valid", acc_q_valid, 0);
      check("cap_slv_ready", slv_q_ready, 1);
      @(negedge clk_i);
      #1;
      check("cap_hold_outstanding", outstanding, 2);
      check("cap_hold_valid", acc_q_valid, 0);
      @(negedge clk_i);
      acc_p.id    = 7'h01;
      acc_p.data  = 32'hB001;
      acc_p_valid = 1'b1;
      #1;
      check("rsp_valid_pass", slv_p_valid, 1);
      check("rsp_id_pass", slv_p.id, 1);
      check("rsp_data_pass", slv_p.data, 32'hB001);
      check("rsp_ready_pass", acc_p_ready, 1);
      slv_p_ready = 1'b0;
      #1;
      check("rsp_ready_low", acc_p_ready, 0);
      slv_p_ready = 1'b1;
      @(negedge clk_i);
      acc_p_valid = 1'b0;
      #1;
      check("ret1_outstanding", outstanding, 1);
      check("iss3_valid", acc_q_valid, 1);
      check("iss3_id", acc_q.id, 3);
      @(negedge clk_i);
      #1;
      check("iss3_outstanding", outstanding, 2);
      check("iss3_head_id", acc_q.id, 4);

      // Same-cycle issue and retire
      @(negedge clk_i);
      acc_p.id    = 7'h02;
      acc_p_valid = 1'b1;
      slv_q.id    = 7'h05;
      slv_q_valid = 1'b1;
      @(negedge clk_i);
      acc_p.id    = 7'h03;
      slv_q_valid = 1'b0;
      #1;
      check("ret2_outstanding", outstanding, 1);
      check("ret2_valid", acc_q_valid, 1);
      check("ret2_head_id", acc_q.id, 4);
      @(negedge clk_i);
      acc_p.id = 7'h04;
      #1;
      check("both_outstanding", outstanding, 1);
      check("both_next_id", acc_q.id, 5);
      check("both_next_valid", acc_q_valid, 1);
      @(negedge clk_i);
      acc_p.id    = 7'h05;
      acc_q_ready = 1'b0;
      #1;
      check("both2_outstanding", outstanding, 1);
      check("both2_valid", acc_q_valid, 0);
      check("both2_busy", busy, 1);
      @(negedge clk_i);
      acc_p_valid = 1'b0;
      #1;
      check("drain_outstanding", outstanding, 0);
      check("drain_busy", busy, 0);
      check("drain_id_err", id_err, 0);

      // Out-of-order response
      @(negedge clk_i);
      slv_q.id    = 7'h10;
      slv_q_valid = 1'b1;
      @(negedge clk_i);
      slv_q.id = 7'h11;
      @(negedge clk_i);
      slv_q_valid = 1'b0;
      acc_q_ready = 1'b1;
      #1;
      check("ooo_iss_a", acc_q.id, 32'h10);
      @(negedge clk_i);
      #1;
      check("ooo_iss_b", acc_q.id, 32'h11);
      @(negedge clk_i);
      acc_q_ready = 1'b0;
      slv_q.id    = 7'h30;
      slv_q_valid = 1'b1;
      #1;
      check("ooo_outstanding", outstanding, 2);
      @(negedge clk_i);
      slv_q_valid = 1'b0;
      acc_p.id    = 7'h11;
      acc_p_valid = 1'b1;
      #1;
      check("ooo_err_not_yet", id_err, 0);
      @(negedge clk_i);
      acc_p.id = 7'h10;
      #1;
      check("ooo_err", id_err, 32'(ErrExp));
      check("ooo_outstanding1", outstanding, 1);
      @(negedge clk_i);
      acc_p_valid = 1'b0;
      #1;
      check("ooo_err_sticky", id_err, 32'(ErrExp));
      check("ooo_outstanding0", outstanding, 0);
      check("ooo_busy_queued", busy, 1);

      // Asynchronous reset mid-operation
      @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      check("arst_id_err", id_err, 0);
      check("arst_busy", busy, 0);
      check("arst_acc_q_valid", acc_q_valid, 0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Spurious response with nothing outstanding
      @(negedge clk_i);
      acc_p.id    = 7'h22;
      acc_p_valid = 1'b1;
      #1;
      check("spur_err_not_yet", id_err, 0);
      @(negedge clk_i);
      acc_p_valid = 1'b0;
      #1;
      check("spur_outstanding", outstanding, 0);
      check("spur_err", id_err, 32'(ErrExp));
      @(negedge clk_i);
      #1;
      check("spur_err_sticky", id_err, 32'(ErrExp));
      check("spur_busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
